// File: rtl/stereo_pan_mixer.sv
// ---------------------------------------------------------------------------
// stereo_pan_mixer
//
// Converts one mono sample into a left/right pair using a linear pan law.
// The pan position is slew-limited once per accepted sample to avoid zipper
// noise. A single signed multiplier is shared between the left and right
// products, and a four-state machine sequences it.
//
// Ports
//   CLOCK_50   in   1   sole clock, rising edge
//   RESET      in   1   asynchronous, active-low reset
//   IN_VALID   in   1   AUDIO_IN / PAN valid this cycle
//   AUDIO_IN   in  16   mono sample, two's complement
//   PAN        in  16   target pan, 0x0000 left .. 0x7FFF right (clamped)
//   LEFT_OUT   out 16   left sample, registered
//   RIGHT_OUT  out 16   right sample, registered
//   OUT_VALID  out  1   one-cycle strobe when LEFT_OUT/RIGHT_OUT update
//   BUSY       out  1   multiplier sequence in progress (MUL_L or MUL_R)
//   OVERRUN    out  1   sticky: IN_VALID arrived while BUSY
// ---------------------------------------------------------------------------
module stereo_pan_mixer #(
  parameter logic [15:0] SLEW_STEP = 16'h0040
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic        IN_VALID,
  input  logic [15:0] AUDIO_IN,
  input  logic [15:0] PAN,
  output logic [15:0] LEFT_OUT,
  output logic [15:0] RIGHT_OUT,
  output logic        OUT_VALID,
  output logic        BUSY,
  output logic        OVERRUN
);

  localparam logic [15:0] GAIN_MAX    = 16'h7FFF;
  localparam logic [15:0] GAIN_CENTRE = 16'h4000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL_L = 2'd1,
    MUL_R = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic               w_accept;
  logic               w_busy;

  logic signed [15:0] r_sample;
  logic [15:0]        r_gain;
  logic [15:0]        r_leftStage;
  logic [15:0]        r_left;
  logic [15:0]        r_right;
  logic               r_outValid;
  logic               r_overrun;

  logic [15:0]        w_target;
  logic               w_stepUp;
  logic [15:0]        w_distance;
  logic [15:0]        w_gainNext;
  logic [15:0]        w_mulGain;
  logic signed [32:0] w_product;
  logic [15:0]        w_mulResult;
  logic               w_unusedProductBits;

  // State register
  always_ff @(posedge CLOCK_50 or negedge RESET) begin
    if (!RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; a new sample is only taken when the multiplier is free
  always_comb begin
    w_nextState = IDLE;
    w_accept    = 1'b0;
    unique case (r_state)
      IDLE, DONE: begin
        if (IN_VALID) begin
          w_accept    = 1'b1;
          w_nextState = MUL_L;
        end else begin
          w_nextState = IDLE;
        end
      end
      MUL_L:   w_nextState = MUL_R;
      MUL_R:   w_nextState = DONE;
      default: w_nextState = IDLE;
    endcase
  end

  assign w_busy = (r_state == MUL_L) || (r_state == MUL_R);

  // Slew limiter: move the gain toward the clamped target by at most
  // SLEW_STEP. Both g and the target are <= 0x7FFF, so g +/- SLEW_STEP
  // cannot wrap when the distance exceeds SLEW_STEP.
  always_comb begin
    w_target   = PAN[15] ? GAIN_MAX : PAN;
    w_stepUp   = (w_target > r_gain);
    w_distance = w_stepUp ? (w_target - r_gain) : (r_gain - w_target);
    if (w_distance <= SLEW_STEP) begin
      w_gainNext = w_target;
    end else if (w_stepUp) begin
      w_gainNext = r_gain + SLEW_STEP;
    end else begin
      w_gainNext = r_gain - SLEW_STEP;
    end
  end

  // Shared multiplier: left gain during MUL_L, right gain otherwise.
  // Gain is zero-extended to 17 bits so it stays positive as a signed operand.
  always_comb begin
    w_mulGain = (r_state == MUL_L) ? (GAIN_MAX - r_gain) : r_gain;
    w_product = $signed(r_sample) * $signed({1'b0, w_mulGain});
  end

  // Arithmetic shift right by 15 with floor; gain <= 0x7FFF keeps the
  // result inside 16 bits, so the upper product bits carry only sign.
  assign w_mulResult         = w_product[30:15];
  assign w_unusedProductBits = ^{w_product[32:31], w_product[14:0]};

  // Datapath registers. The right product goes straight into RIGHT_OUT on
  // the same edge the left staging value is copied, so both outputs and
  // OUT_VALID change together when the state enters DONE.
  always_ff @(posedge CLOCK_50 or negedge RESET) begin
    if (!RESET) begin
      r_sample    <= '0;
      r_gain      <= GAIN_CENTRE;
      r_leftStage <= '0;
      r_left      <= '0;
      r_right     <= '0;
      r_outValid  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_outValid <= 1'b0;
      if (w_accept) begin
        r_sample <= AUDIO_IN;
        r_gain   <= w_gainNext;
      end
      if (IN_VALID && w_busy) begin
        r_overrun <= 1'b1;
      end
      if (r_state == MUL_L) begin
        r_leftStage <= w_mulResult;
      end
      if (r_state == MUL_R) begin
        r_left     <= r_leftStage;
        r_right    <= w_mulResult;
        r_outValid <= 1'b1;
      end
    end
  end

  assign LEFT_OUT  = r_left;
  assign RIGHT_OUT = r_right;
  assign OUT_VALID = r_outValid;
  assign BUSY      = w_busy;
  assign OVERRUN   = r_overrun;

endmodule

// File: tb/tb_stereo_pan_mixer.sv
// ---------------------------------------------------------------------------
// tb_stereo_pan_mixer
//
// Directed bench for stereo_pan_mixer. Expected output values are worked out
// by hand from the pan law: result = floor(sample * gain / 2^15), with the
// right gain g and the left gain 0x7FFF - g.
// ---------------------------------------------------------------------------
module tb_stereo_pan_mixer;

  logic        CLOCK_50;
  logic        RESET;
  logic        IN_VALID;
  logic [15:0] AUDIO_IN;
  logic [15:0] PAN;
  logic [15:0] LEFT_OUT;
  logic [15:0] RIGHT_OUT;
  logic        OUT_VALID;
  logic        BUSY;
  logic        OVERRUN;

  int checkCount;
  int errorCount;

  stereo_pan_mixer #(.SLEW_STEP(16'h0040)) dut (
    .CLOCK_50  (CLOCK_50),
    .RESET     (RESET),
    .IN_VALID  (IN_VALID),
    .AUDIO_IN  (AUDIO_IN),
    .PAN       (PAN),
    .LEFT_OUT  (LEFT_OUT),
    .RIGHT_OUT (RIGHT_OUT),
    .OUT_VALID (OUT_VALID),
    .BUSY      (BUSY),
    .OVERRUN   (OVERRUN)
  );

  // 50 MHz clock
  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  // Single comparison point: counts and reports any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Present one sample for a single cycle; returns at the falling edge one
  // cycle after the accepting rising edge
  task automatic applyStimulus(input logic [15:0] audio, input logic [15:0] pan);
    @(negedge CLOCK_50);
    IN_VALID = 1'b1;
    AUDIO_IN = audio;
    PAN      = pan;
    @(negedge CLOCK_50);
    IN_VALID = 1'b0;
  endtask

  // Wait (bounded) for OUT_VALID; latency is counted in cycles after the
  // accepting edge, 99 marks a timeout
  task automatic waitResult(output logic [15:0] left, output logic [15:0] right,
                            output int latency);
    latency = 1;
    while (!OUT_VALID && latency < 8) begin
      @(negedge CLOCK_50);
      latency++;
    end
    if (!OUT_VALID) latency = 99;
    left  = LEFT_OUT;
    right = RIGHT_OUT;
  endtask

  // Full sample round trip with checks on latency, values and strobe width
  task automatic runSample(input string tag, input logic [15:0] audio,
                           input logic [15:0] pan, input logic [15:0] expLeft,
                           input logic [15:0] expRight);
    logic [15:0] l, r;
    int          lat;
    applyStimulus(audio, pan);
    checkOutput({tag, "_busy"}, {31'd0, BUSY}, 32'd1);
    waitResult(l, r, lat);
    checkOutput({tag, "_latency"}, lat, 32'd3);
    checkOutput({tag, "_left"}, {16'd0, l}, {16'd0, expLeft});
    checkOutput({tag, "_right"}, {16'd0, r}, {16'd0, expRight});
    @(negedge CLOCK_50);
    checkOutput({tag, "_validPulse"}, {31'd0, OUT_VALID}, 32'd0);
  endtask

  task automatic pulseReset();
    @(negedge CLOCK_50);
    RESET = 1'b0;
    @(negedge CLOCK_50);
    RESET = 1'b1;
  endtask

  initial begin
    logic [15:0] l, r;
    int          lat;
    int          validCount;
    int          lastValid;
    int          gapErrors;

    checkCount = 0;
    errorCount = 0;
    RESET      = 1'b0;
    IN_VALID   = 1'b0;
    AUDIO_IN   = '0;
    PAN        = '0;

    // Reset state while RESET is held low
    #15;
    checkOutput("reset_left",    {16'd0, LEFT_OUT},  32'd0);
    checkOutput("reset_right",   {16'd0, RIGHT_OUT}, 32'd0);
    checkOutput("reset_valid",   {31'd0, OUT_VALID}, 32'd0);
    checkOutput("reset_busy",    {31'd0, BUSY},      32'd0);
    checkOutput("reset_overrun", {31'd0, OVERRUN},   32'd0);
    @(negedge CLOCK_50);
    RESET = 1'b1;

    // Centre pan, positive and negative full-scale-ish samples
    runSample("centrePos", 16'h4000, 16'h4000, 16'h1FFF, 16'h2000);
    runSample("centreNeg", 16'h8000, 16'h4000, 16'hC001, 16'hC000);

    // Pulses every 3 cycles are accepted in DONE back-to-back
    validCount = 0;
    lastValid  = -1;
    gapErrors  = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge CLOCK_50);
      if (OUT_VALID) begin
        if (lastValid >= 0 && (i - lastValid) != 3) gapErrors++;
        lastValid = i;
        validCount++;
      end
      IN_VALID = (i % 3 == 0) && (i < 9);
      AUDIO_IN = 16'h4000;
      PAN      = 16'h4000;
    end
    IN_VALID = 1'b0;
    checkOutput("thru_validCount", validCount, 32'd3);
    checkOutput("thru_gap",        gapErrors,  32'd0);
    checkOutput("thru_lastPos",    lastValid,  32'd9);
    checkOutput("thru_overrun",    {31'd0, OVERRUN}, 32'd0);

    // Pulse one cycle after an accept is dropped and flags overrun
    applyStimulus(16'h4000, 16'h4000);
    IN_VALID = 1'b1;
    AUDIO_IN = 16'h1000;
    PAN      = 16'h7FFF;
    @(negedge CLOCK_50);
    IN_VALID   = 1'b0;
    validCount = 0;
    for (int i = 0; i < 8; i++) begin
      if (OUT_VALID) begin
        validCount++;
        l = LEFT_OUT;
        r = RIGHT_OUT;
      end
      @(negedge CLOCK_50);
    end
    checkOutput("ovr_flag",       {31'd0, OVERRUN}, 32'd1);
    checkOutput("ovr_validCount", validCount, 32'd1);
    checkOutput("ovr_left",       {16'd0, l}, 32'h1FFF);
    checkOutput("ovr_right",      {16'd0, r}, 32'h2000);
    // Gain must not have moved toward the dropped PAN
    runSample("afterOvr", 16'h4000, 16'h4000, 16'h1FFF, 16'h2000);
    checkOutput("ovr_sticky", {31'd0, OVERRUN}, 32'd1);

    // Move gain off centre, then reset in MUL_R of a later sample
    runSample("preReset", 16'h7FFF, 16'h7FFF, 16'h3FBE, 16'h403F);
    applyStimulus(16'h4000, 16'h7FFF);
    @(negedge CLOCK_50);
    checkOutput("midR_busy", {31'd0, BUSY}, 32'd1);
    RESET = 1'b0;
    #1;
    checkOutput("midR_left",    {16'd0, LEFT_OUT},  32'd0);
    checkOutput("midR_right",   {16'd0, RIGHT_OUT}, 32'd0);
    checkOutput("midR_valid",   {31'd0, OUT_VALID}, 32'd0);
    checkOutput("midR_busy0",   {31'd0, BUSY},      32'd0);
    checkOutput("midR_overrun", {31'd0, OVERRUN},   32'd0);
    @(negedge CLOCK_50);
    RESET      = 1'b1;
    validCount = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLOCK_50);
      if (OUT_VALID) validCount++;
    end
    checkOutput("midR_noValid", validCount, 32'd0);
    // From g=0x4000, PAN=0 steps to 0x3FC0: right 0x1FE0, left 0x201F
    runSample("gainReset", 16'h4000, 16'h0000, 16'h201F, 16'h1FE0);

    // Slew from centre toward clamped full right
    pulseReset();
    for (int n = 1; n <= 300; n++) begin
      applyStimulus(16'h7FFF, 16'hFFFF);
      waitResult(l, r, lat);
      if (n == 1) begin
        checkOutput("slew1_left",  {16'd0, l}, 32'h3FBE);
        checkOutput("slew1_right", {16'd0, r}, 32'h403F);
        checkOutput("slew1_lat",   lat, 32'd3);
      end else if (n == 255) begin
        checkOutput("slew255_left",  {16'd0, l}, 32'h003E);
        checkOutput("slew255_right", {16'd0, r}, 32'h7FBF);
      end else if (n == 256 || n == 300) begin
        checkOutput("slewEnd_left",  {16'd0, l}, 32'h0000);
        checkOutput("slewEnd_right", {16'd0, r}, 32'h7FFE);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/stereo_pan_mixer.md
# stereo_pan_mixer

Stereo pan stage that sits directly downstream of the autopanner. It takes a mono signed audio sample and the 16-bit pan position produced by the autopanner (0x0000 full left, 0x4000 centre, 0x7FFF full right). It produces gain-scaled left and right samples for the output codec path. A per-sample slew limiter removes zipper noise on pan jumps, and one time-shared signed multiplier is sequenced by a small state machine.

## Interface
Parameters:
- SLEW_STEP, 16'h0040: maximum change of the internal pan gain per accepted sample (unsigned; 0 is illegal).

Ports:
- CLOCK_50, input, 1: the only clock; all state updates on the rising edge.
- RESET, input, 1: reset is asynchronous and active-low. Low forces all state to reset values immediately.
- IN_VALID, input, 1: one-cycle strobe meaning AUDIO_IN and PAN are valid this cycle.
- AUDIO_IN, input, 16: mono sample, two's complement.
- PAN, input, 16: target pan position, unsigned. Values above 0x7FFF are clamped to 0x7FFF.
- LEFT_OUT, output, 16: left sample, two's complement, registered.
- RIGHT_OUT, output, 16: right sample, two's complement, registered.
- OUT_VALID, output, 1: high for exactly one cycle when LEFT_OUT and RIGHT_OUT update.
- BUSY, output, 1: high while the state is MUL_L or MUL_R. IN_VALID is not accepted while BUSY is high.
- OVERRUN, output, 1: sticky flag, set when IN_VALID arrives while BUSY is high. Cleared only by RESET.

## Operation
State machine states: IDLE, MUL_L, MUL_R, DONE.
- IDLE or DONE with IN_VALID=1: accept the sample; next state MUL_L.
- IDLE or DONE with IN_VALID=0: next state IDLE.
- MUL_L: next state MUL_R.
- MUL_R: next state DONE.

On accept:
- Latch AUDIO_IN into the sample register.
- Compute tgt = min(PAN, 0x7FFF).
- Update the gain register g toward tgt:
  - if |tgt − g| ≤ SLEW_STEP, then g = tgt;
  - otherwise g = g ± SLEW_STEP, stepping toward tgt.
- The updated g is the gain used for this sample.

Gains:
- Right gain gR = g.
- Left gain gL = 0x7FFF − g. This is a linear pan law; gL + gR = 0x7FFF always.

Arithmetic:
- Product = signed(sample) × signed({1'b0, gain}), 33-bit signed.
- Result = product >>> 15, truncated (floor), taking bits [30:15].
- Overflow cannot occur because gain ≤ 0x7FFF, so no saturation logic is needed.

Multiplier use:
- MUL_L computes the left product into a staging register.
- MUL_R computes the right product into a staging register.
- In DONE, both staging values are copied to LEFT_OUT and RIGHT_OUT in the same edge, and OUT_VALID is high.

Other rules:
- IN_VALID during MUL_L or MUL_R is dropped: no latch, no g update, OVERRUN set.
- PAN changes with no accepted sample have no effect.
- Outputs hold their last values between updates.

Reset values:
- state = IDLE
- g = 0x4000
- sample and staging registers = 0
- LEFT_OUT = 0x0000, RIGHT_OUT = 0x0000
- OUT_VALID = 0, BUSY = 0, OVERRUN = 0

## Timing
- Accept at edge N (IN_VALID high in cycle N with state IDLE or DONE).
- BUSY is high in cycles N+1 and N+2.
- LEFT_OUT, RIGHT_OUT and OUT_VALID become valid in cycle N+3. Latency is 3 cycles.
- Maximum throughput is one sample per 3 cycles, since DONE accepts back-to-back.
- Back-to-back case: a sample accepted in DONE gives OUT_VALID in cycle N+3 and the next OUT_VALID in cycle N+6.
- Reset mid-operation: the in-flight sample is discarded and no OUT_VALID is produced. After RESET deasserts, the first IN_VALID is accepted normally.
- The gain update and the sample latch happen on the same edge; the pan value and the audio value come from the same cycle.

## Test plan
- Reset: assert RESET=0 mid-MUL_R. Outputs go to 0 immediately, OUT_VALID and BUSY are 0, no OUT_VALID follows, and g is back at 0x4000.
- Centre, positive input: after reset, AUDIO_IN=0x4000, PAN=0x4000, one IN_VALID. Three cycles later LEFT_OUT=0x1FFF, RIGHT_OUT=0x2000, OUT_VALID high for one cycle.
- Centre, negative input: AUDIO_IN=0x8000, PAN=0x4000. Expect LEFT_OUT=0xC001, RIGHT_OUT=0xC000.
- Slew: after reset, hold PAN=0xFFFF (clamps to 0x7FFF) and AUDIO_IN=0x7FFF.
  - 1st sample uses g=0x4040.
  - 255th sample uses g=0x7FC0.
  - 256th and later samples: RIGHT_OUT=0x7FFE, LEFT_OUT=0x0000.
- Overrun and throughput:
  - IN_VALID pulses every 3 cycles: OUT_VALID every 3 cycles and OVERRUN stays 0.
  - A pulse 1 cycle after an accept: dropped, no extra OUT_VALID, OVERRUN=1 and stays set until reset.
